// File: rtl/signed_acc_if.sv
// Sample stream into signed_acc and the completed frame sums coming back out.
// The master drives samples and framing controls; the slave (the accumulator) returns sums.
interface signed_acc_if #(
  parameter int DIN_WIDTH    = 8,
  parameter int ACC_LEN_BITS = 4
);
  localparam int DOUT_WIDTH = DIN_WIDTH + ACC_LEN_BITS;

  logic [DIN_WIDTH-1:0]    din;
  logic                    din_valid;
  logic [ACC_LEN_BITS-1:0] acc_len;
  logic                    sync;
  logic [DOUT_WIDTH-1:0]   dout;
  logic                    dout_valid;

  modport master (
    output din, din_valid, acc_len, sync,
    input  dout, dout_valid
  );

  modport slave (
    input  din, din_valid, acc_len, sync,
    output dout, dout_valid
  );
endinterface

// File: rtl/signed_acc.sv
// Frame accumulator: sums acc_len signed samples (0 means 2**ACC_LEN_BITS) at full
// growth and pulses dout_valid once per completed frame; sync abandons a partial frame.
module signed_acc #(
  parameter int DIN_WIDTH    = 8,
  parameter int DIN_POINT    = 4,
  parameter int ACC_LEN_BITS = 4
) (
  input logic         clk,
  input logic         rst,
  signed_acc_if.slave bus
);
  localparam int DOUT_WIDTH = DIN_WIDTH + ACC_LEN_BITS;

  // The output keeps the input binary point, so it must fit inside the sample.
  if (DIN_POINT < 0 || DIN_POINT > DIN_WIDTH) begin : g_point_check
    $error("signed_acc: DIN_POINT must lie within 0..DIN_WIDTH");
  end

  logic [DOUT_WIDTH-1:0]   acc        = '0;
  logic [ACC_LEN_BITS-1:0] cnt        = '0;
  logic [ACC_LEN_BITS-1:0] len_reg    = '0;
  logic [DOUT_WIDTH-1:0]   dout_r     = '0;
  logic                    dout_valid_r = 1'b0;

  logic                    frame_start;
  logic [ACC_LEN_BITS-1:0] cur_cnt;
  logic [ACC_LEN_BITS-1:0] cur_len;
  logic [ACC_LEN_BITS-1:0] last_idx;
  logic [DOUT_WIDTH-1:0]   din_ext;
  logic [DOUT_WIDTH-1:0]   base;
  logic [DOUT_WIDTH-1:0]   sum;
  logic                    frame_done;

  // A sample taken at cnt==0 or alongside sync opens a frame with the live acc_len.
  // len-1 wraps 0 to all ones, which is exactly the last index of a 2**N frame.
  always_comb begin
    frame_start = 1'b0;
    cur_cnt     = cnt;
    cur_len     = len_reg;
    base        = acc;
    frame_start = bus.sync || (cnt == '0);
    if (frame_start) begin
      cur_cnt = '0;
      cur_len = bus.acc_len;
      base    = '0;
    end
    last_idx   = cur_len - ACC_LEN_BITS'(1);
    din_ext    = {{ACC_LEN_BITS{bus.din[DIN_WIDTH-1]}}, bus.din};
    sum        = base + din_ext;
    frame_done = (cur_cnt == last_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      cnt          <= '0;
      len_reg      <= '0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
    end else begin
      dout_valid_r <= 1'b0;
      if (bus.din_valid) begin
        if (frame_start) begin
          len_reg <= bus.acc_len;
        end
        if (frame_done) begin
          dout_r       <= sum;
          dout_valid_r <= 1'b1;
          acc          <= '0;
          cnt          <= '0;
        end else begin
          acc <= sum;
          cnt <= cur_cnt + ACC_LEN_BITS'(1);
        end
      end else if (bus.sync) begin
        acc <= '0;
        cnt <= '0;
      end
    end
  end

  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;

endmodule

// File: doc/signed_acc.md
SIGNED_ACC -- requirements
Module: signed_acc

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 8, input sample width (signed two's complement).
REQ-002 SHALL have parameter DIN_POINT, default 4, input fractional bits; output keeps the same binary point.
REQ-003 SHALL have parameter ACC_LEN_BITS, default 4, width of the frame-length control.
REQ-004 SHALL have localparam DOUT_WIDTH = DIN_WIDTH+ACC_LEN_BITS, full-growth output width.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port din  input  DIN_WIDTH  signed sample.
REQ-008 SHALL have port din_valid  input  1  din qualifier; one sample accepted per high cycle.
REQ-009 SHALL have port acc_len  input  ACC_LEN_BITS  samples per frame; 0 means 2**ACC_LEN_BITS.
REQ-010 SHALL have port sync  input  1  abandons the partial frame and restarts framing.
REQ-011 SHALL have port dout  output  DOUT_WIDTH  signed frame sum, DOUT_POINT = DIN_POINT, for a downstream signed cast.
REQ-012 SHALL have port dout_valid  output  1  one-cycle pulse per completed frame.

Function
REQ-013 SHALL sign-extend din to DOUT_WIDTH before addition; sum never overflows for any acc_len.
REQ-014 SHALL keep a sample counter cnt (0..len-1) and accumulator acc (DOUT_WIDTH bits).
REQ-015 SHALL latch acc_len into len_reg when a sample is accepted with cnt==0; acc_len changes mid-frame affect only the next frame.
REQ-016 SHALL, on accepted sample with cnt!=len-1: acc <= acc+din, cnt <= cnt+1.
REQ-017 SHALL, on accepted sample with cnt==len-1: dout <= acc+din, dout_valid <= 1, acc <= 0, cnt <= 0.
REQ-018 SHALL treat len==1 (acc_len==1) as every sample completing a frame: dout <= din sign-extended.
REQ-019 SHALL assert dout_valid exactly one cycle after the last sample of the frame, for exactly one cycle.
REQ-020 SHALL hold acc, cnt, len_reg and dout unchanged on cycles with din_valid low and sync low.
REQ-021 SHALL hold dout at its last frame value between dout_valid pulses.
REQ-022 SHALL, on sync high with din_valid low: acc <= 0, cnt <= 0, no dout_valid.
REQ-023 SHALL, on sync high with din_valid high: discard the partial frame and take din as sample 0 of a new frame (acc <= din, cnt <= 1, len_reg <= acc_len); if the new len is 1, complete the frame per REQ-018.
REQ-024 SHALL not emit dout_valid for a frame abandoned by sync or rst.
REQ-025 SHALL accept back-to-back valid samples at full rate with no dead cycle across frame boundaries.

Reset
REQ-026 SHALL, on rst high at a clock edge, set acc=0, cnt=0, len_reg=0, dout=0, dout_valid=0, overriding din_valid and sync.
REQ-027 SHALL, after reset, start the next frame on the first accepted sample; power-up register values equal reset values.

Verification (DIN_WIDTH=8, DIN_POINT=4, ACC_LEN_BITS=4, DOUT_WIDTH=12)
REQ-028 SHALL cover: acc_len=4, din=1,2,3,4 on consecutive valid cycles -> dout=10, dout_valid high one cycle after the 4th sample only.
REQ-029 SHALL cover: same samples with 0-3 idle cycles between them -> dout=10; pulse tied to the 4th valid; dout stable afterwards.
REQ-030 SHALL cover: acc_len=0, 16 samples of -128 -> dout=-2048 (0x800); 16 samples of +127 -> dout=2032 (0x7F0), back-to-back frames, no gap.
REQ-031 SHALL cover: acc_len=4, samples 9,9 then sync with sample 5, then 5,5,5 -> single dout_valid, dout=20; no output for the 9,9 frame.
REQ-032 SHALL cover: rst asserted after 2 of 4 samples -> dout=0, dout_valid=0 next cycle; then 1,1,1,1 -> dout=4.
REQ-033 SHALL cover: acc_len switched 4->2 after sample 1 of a frame -> current frame sums 4 samples; following frames sum 2 samples.
